// File: rtl/reg_bank_pkg.sv
// Shared types and default geometry for the register bank.
`timescale 1ns/1ps
package reg_bank_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/reg_word.sv
// One storage word: enable-gated register with a synchronous clear that outranks the write.
`timescale 1ns/1ps
module reg_word #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= '0;
      end else if (clr) begin
         q_reg <= '0;
      end else if (en) begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/reg_bank.sv
// Register bank with registered read, write-through bypass and a one-word-per-cycle clear sequence.
`timescale 1ns/1ps
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             clr_start,
   output logic             busy
);

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t           state_reg, state_next;
   logic [AW-1:0]    clr_idx_reg, clr_idx_next;
   logic             accept, wr_ok, rd_ok;
   logic             wr_in_range, rd_in_range;
   logic [WIDTH-1:0] word_q [DEPTH];
   logic [WIDTH-1:0] rd_word, rd_data_next;
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         clr_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_idx_reg <= clr_idx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_idx_next = clr_idx_reg;
      case (state_reg)
         IDLE: begin
            if (clr_start) begin
               state_next   = CLEAR;
               clr_idx_next = '0;
            end
         end
         CLEAR: begin
            if (clr_idx_reg == LAST_IDX) begin
               state_next   = IDLE;
               clr_idx_next = '0;
            end else begin
               clr_idx_next = clr_idx_reg + 1'b1;
            end
         end
         default: begin
            state_next   = IDLE;
            clr_idx_next = '0;
         end
      endcase
   end

   // A clear request in IDLE swallows any read or write presented with it.
   assign accept      = (state_reg == IDLE) && !clr_start;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
   assign wr_ok       = accept && wr_en && wr_in_range;
   assign rd_ok       = accept && rd_en;
   assign busy        = (state_reg == CLEAR);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         reg_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (wr_data),
            .en    (wr_ok && (wr_addr == AW'(gi))),
            .clr   (busy && (clr_idx_reg == AW'(gi))),
            .q     (word_q[gi])
         );
      end
   endgenerate

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_word = word_q[i];
         end
      end
   end

   always_comb begin
      rd_data_next = rd_word;
      if (!rd_in_range) begin
         rd_data_next = '0;
      end else if (wr_ok && (wr_addr == rd_addr)) begin
         rd_data_next = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_ok;
         if (rd_ok) begin
            rd_data_reg <= rd_data_next;
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_reg_bank.sv
// Randomised and directed checks of reg_bank against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       wr_en, rd_en, clr_start;
   logic [2:0] wr_addr, rd_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       rd_valid, busy;

   logic       wr_en5, rd_en5, clr_start5;
   logic [2:0] wr_addr5, rd_addr5;
   logic [7:0] wr_data5;
   logic [7:0] rd_data5;
   logic       rd_valid5, busy5;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem_m [8];
   int         busy_left;
   int         clr_pos;
   logic [7:0] exp_data;
   logic       exp_valid;

   always #5 clk = ~clk;

   reg_bank #(.WIDTH(8), .DEPTH(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .clr_start (clr_start),
      .busy      (busy)
   );

   reg_bank #(.WIDTH(8), .DEPTH(5)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en5),
      .wr_addr   (wr_addr5),
      .wr_data   (wr_data5),
      .rd_en     (rd_en5),
      .rd_addr   (rd_addr5),
      .rd_data   (rd_data5),
      .rd_valid  (rd_valid5),
      .clr_start (clr_start5),
      .busy      (busy5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
      busy_left = 0;
      clr_pos   = 0;
      exp_data  = 8'h00;
      exp_valid = 1'b0;
   endtask

   // Behaviour of one rising edge: clear countdown, else clear request, else read/write.
   task automatic model_step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                             input logic re, input logic [2:0] ra, input logic cs);
      if (busy_left > 0) begin
         mem_m[clr_pos] = 8'h00;
         clr_pos++;
         busy_left--;
         exp_valid = 1'b0;
      end else if (cs) begin
         busy_left = 8;
         clr_pos   = 0;
         exp_valid = 1'b0;
      end else begin
         exp_valid = re;
         if (re) exp_data = (we && wa == ra) ? wd : mem_m[ra];
         if (we) mem_m[wa] = wd;
      end
   endtask

   task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra, input logic cs);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra; clr_start = cs;
      @(posedge clk);
      model_step(we, wa, wd, re, ra, cs);
      #1;
      $display("cyc t=%0t we=%0b wa=%0d wd=%02h re=%0b ra=%0d cs=%0b -> rd=%02h v=%0b busy=%0b",
               $time, we, wa, wd, re, ra, cs, rd_data, rd_valid, busy);
      check("rd_valid", rd_valid, exp_valid);
      check("busy", busy, (busy_left > 0));
      check("rd_data", rd_data, exp_data);
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic cycle5(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra);
      wr_en5 = we; wr_addr5 = wa; wr_data5 = wd;
      rd_en5 = re; rd_addr5 = ra; clr_start5 = 1'b0;
      @(posedge clk);
      #1;
      $display("d5 t=%0t we=%0b wa=%0d wd=%02h re=%0b ra=%0d -> rd=%02h v=%0b",
               $time, we, wa, wd, re, ra, rd_data5, rd_valid5);
   endtask

   initial begin
      int n_busy;
      wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; clr_start = 0;
      wr_en5 = 0; wr_addr5 = 0; wr_data5 = 0; rd_en5 = 0; rd_addr5 = 0; clr_start5 = 0;
      model_reset();

      #12;
      check("reset_rd_data", rd_data, 8'h00);
      check("reset_rd_valid", rd_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst_n = 1'b1;

      // Write then read back with one-cycle latency.
      cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0);
      check("wr_rd_a5_data", rd_data, 8'hA5);
      check("wr_rd_a5_valid", rd_valid, 1'b1);
      idle_cycle();
      check("valid_drops", rd_valid, 1'b0);

      // Same-cycle read and write returns the new data.
      cycle(1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 1'b0);
      check("bypass_3c", rd_data, 8'h3C);

      // Fill, clear, and confirm the clear lasts DEPTH cycles and ignores writes.
      for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'((i + 1) * 8'h11), 1'b0, 3'd0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
      n_busy = (busy === 1'b1) ? 1 : 0;
      cycle(1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0);
      if (busy === 1'b1) n_busy++;
      while (busy === 1'b1 && n_busy < 20) begin
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         if (busy === 1'b1) n_busy++;
      end
      check("clear_busy_len", n_busy, 8);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0);
         check("after_clear_zero", rd_data, 8'h00);
      end

      // Clear request outranks a simultaneous write.
      cycle(1'b1, 3'd1, 8'h12, 1'b0, 3'd0, 1'b0);
      cycle(1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 8; i++) idle_cycle();
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0);
      check("clr_beats_write", rd_data, 8'h00);

      // Asynchronous reset in the middle of a clear.
      for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'((i + 1) * 8'h11), 1'b0, 3'd0, 1'b0);
      cycle(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0);
      check("pre_reset_66", rd_data, 8'h66);
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) idle_cycle();
      check("mid_clear_busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_rd_data", rd_data, 8'h00);
      check("async_rst_rd_valid", rd_valid, 1'b0);
      rst_n = 1'b1;
      model_reset();
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0);
      check("post_rst_addr6", rd_data, 8'h00);
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0);
      check("post_rst_addr7", rd_data, 8'h00);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 39) == 0));
      end
      wr_en = 0; rd_en = 0; clr_start = 0;

      // DEPTH=5 instance: out-of-range addresses.
      for (int i = 0; i < 5; i++) cycle5(1'b1, 3'(i), 8'((i + 1) * 8'h10), 1'b0, 3'd0);
      cycle5(1'b1, 3'd6, 8'h99, 1'b0, 3'd0);
      cycle5(1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
      check("d5_oor_valid", rd_valid5, 1'b1);
      check("d5_oor_data", rd_data5, 8'h00);
      for (int i = 0; i < 5; i++) begin
         cycle5(1'b0, 3'd0, 8'h00, 1'b1, 3'(i));
         check("d5_word_kept", rd_data5, 8'((i + 1) * 8'h10));
      end
      cycle5(1'b1, 3'd5, 8'h5A, 1'b1, 3'd5);
      check("d5_oor_bypass", rd_data5, 8'h00);
      cycle5(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      check("d5_idle_valid", rd_valid5, 1'b0);
      check("d5_idle_hold", rd_data5, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word.
REQ-002 Parameter DEPTH, default 8, number of words; legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH), address width; derived, not overridden.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  write request, sampled each rising edge.
REQ-007 wr_addr  in  AW  write word address.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 rd_en  in  1  read request, sampled each rising edge.
REQ-010 rd_addr  in  AW  read word address.
REQ-011 rd_data  out  WIDTH  registered read data.
REQ-012 rd_valid  out  1  one-cycle pulse; rd_data updated this cycle.
REQ-013 clr_start  in  1  request to zero every word.
REQ-014 busy  out  1  high while the clear sequence runs.

Function
REQ-015 The block SHALL have a two-state FSM: IDLE and CLEAR.
REQ-016 In IDLE with clr_start=1, the FSM SHALL go to CLEAR at the next edge and drop any wr_en/rd_en in that cycle; clr_start has top priority.
REQ-017 In CLEAR, the block SHALL zero one word per cycle at clear index 0,1,...,DEPTH-1, then return to IDLE; the sequence takes exactly DEPTH cycles.
REQ-018 busy SHALL be 1 exactly while the FSM is in CLEAR: from the edge after clr_start is sampled, for DEPTH cycles.
REQ-019 While busy=1, wr_en, rd_en and clr_start SHALL be ignored, with no memory change other than the clear and no rd_valid pulse.
REQ-020 In IDLE with wr_en=1 and wr_addr<DEPTH, mem[wr_addr] SHALL take wr_data at the edge; wr_addr>=DEPTH SHALL be ignored.
REQ-021 In IDLE with rd_en=1, rd_data SHALL show mem[rd_addr] one cycle later with rd_valid=1 for that cycle (latency 1).
REQ-022 A read with rd_addr>=DEPTH SHALL return all-zero data and still pulse rd_valid.
REQ-023 A read and a write to the same address in the same cycle SHALL return the new wr_data (write-through bypass).
REQ-024 When no read is accepted, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-025 Unaddressed words SHALL keep their value every cycle.

Reset
REQ-026 rst_n=0 SHALL, without waiting for clk, force all words to 0, rd_data=0, rd_valid=0, busy=0, FSM=IDLE and clear index=0.
REQ-027 A reset asserted during CLEAR SHALL abort the sequence; after release the block SHALL be in IDLE with all words zero.
REQ-028 The first accepted request SHALL be the one on the first rising edge after rst_n rises.

Structure
REQ-029 Shared package reg_bank_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the WIDTH/DEPTH default constants.
REQ-030 Storage SHALL be DEPTH instances of sub-module reg_word: a WIDTH-bit enable-gated register with async active-low reset and inputs d, en, clr.
REQ-031 Address decode, read mux, bypass and FSM SHALL live in reg_bank.

Verification (WIDTH=8, DEPTH=8)
REQ-032 Reset, then write 0xA5 to addr 3, read addr 3 the next cycle -> rd_data=0xA5, rd_valid=1 exactly one cycle after rd_en.
REQ-033 Write 0x3C to addr 5 and read addr 5 in the same cycle (old value 0x00) -> rd_data=0x3C next cycle.
REQ-034 Fill addr 0..7 with 0x11..0x88, pulse clr_start -> busy=1 for exactly 8 cycles; wr_en(addr 2, 0xFF) during busy dropped; reads after busy falls return 0x00 at all addrs.
REQ-035 clr_start and wr_en(addr 1, 0x77) in the same IDLE cycle -> write dropped, clear runs, addr 1 reads 0x00.
REQ-036 rst_n low for 1 ns mid-CLEAR (after 3 words cleared, addr 6=0x66) -> busy=0 at once, all outputs 0, addr 6 reads 0x00 after release.
REQ-037 Instance DEPTH=5: write 0x99 to addr 6, read addr 6 -> rd_valid=1, rd_data=0x00, addr 0..4 unchanged.
